// File: rtl/rr_dff_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register.
// N requesters compete. The winner is granted for one cycle, and its D word
// is loaded into Q on the next edge with a one-cycle ACK. HOLD idle cycles
// then pass before another request is sampled.
module rr_dff_arbiter #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int HOLD = 2,
   localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic           i_ck,
   input  logic           i_rst,
   input  logic [N-1:0]   i_req,
   input  logic [N*W-1:0] i_d,
   output logic [N-1:0]   o_gnt,
   output logic           o_ack,
   output logic [W-1:0]   o_q,
   output logic [IW-1:0]  o_owner,
   output logic           o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

   localparam logic [3:0] HOLD_M1 = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;

   state_t        r_state, w_state_nx;
   logic [IW-1:0] r_ptr, w_ptr_nx;
   logic [3:0]    r_cnt, w_cnt_nx;
   logic [N-1:0]  r_gnt, w_gnt_nx;
   logic          r_ack, w_ack_nx;
   logic [W-1:0]  r_q, w_q_nx;
   logic [IW-1:0] r_owner, w_owner_nx;
   logic          r_busy, w_busy_nx;
   logic [IW-1:0] w_win;
   int            w_idx;

   // Winner search: the requester closest to the pointer, in wrapping order.
   // The loop runs from the farthest offset down, so the nearest hit is written last.
   always_comb begin
      w_win = '0;
      w_idx = 0;
      for (int off = N - 1; off >= 0; off--) begin
         w_idx = int'(r_ptr) + off;
         if (w_idx >= N) w_idx = w_idx - N;
         if (i_req[w_idx[IW-1:0]]) w_win = IW'(w_idx);
      end
   end

   // Next-state and next-output logic. ACK defaults low, so it is a single-cycle pulse.
   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_cnt_nx   = r_cnt;
      w_gnt_nx   = r_gnt;
      w_ack_nx   = 1'b0;
      w_q_nx     = r_q;
      w_owner_nx = r_owner;
      w_busy_nx  = r_busy;
      case (r_state)
         S_IDLE: begin
            if (|i_req) begin
               w_gnt_nx   = N'(1) << w_win;
               w_owner_nx = w_win;
               w_busy_nx  = 1'b1;
               w_state_nx = S_GRANT;
            end
         end
         S_GRANT: begin
            // The write is committed here; REQ is not looked at again.
            w_q_nx   = W'(i_d >> (int'(r_owner) * W));
            w_ack_nx = 1'b1;
            w_gnt_nx = '0;
            w_ptr_nx = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);
            if (HOLD == 0) begin
               w_state_nx = S_IDLE;
               w_busy_nx  = 1'b0;
            end else begin
               w_state_nx = S_HOLD;
               w_cnt_nx   = HOLD_M1;
            end
         end
         S_HOLD: begin
            if (r_cnt == 4'd0) begin
               w_state_nx = S_IDLE;
               w_busy_nx  = 1'b0;
            end else begin
               w_cnt_nx = r_cnt - 4'd1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State and output registers. Reset aborts any write in progress.
   always_ff @(posedge i_ck or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_ack   <= 1'b0;
         r_q     <= '0;
         r_owner <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
         r_cnt   <= w_cnt_nx;
         r_gnt   <= w_gnt_nx;
         r_ack   <= w_ack_nx;
         r_q     <= w_q_nx;
         r_owner <= w_owner_nx;
         r_busy  <= w_busy_nx;
      end
   end

   assign o_gnt   = r_gnt;
   assign o_ack   = r_ack;
   assign o_q     = r_q;
   assign o_owner = r_owner;
   assign o_busy  = r_busy;

endmodule

// File: tb/tb_rr_dff_arbiter.sv
// Bench for rr_dff_arbiter: one HOLD=2 instance and one HOLD=0 instance.
// A timestamp-based model predicts the outputs on every cycle.
// Directed scenarios also check hand-computed literal values.
module tb_rr_dff_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req0 = '0, req1 = '0;
   logic [N*W-1:0] d0 = '0, d1 = '0;
   logic [N-1:0]   gnt0, gnt1;
   logic           ack0, ack1, busy0, busy1;
   logic [W-1:0]   q0, q1;
   logic [1:0]     own0, own1;

   int n_tests = 0;
   int n_fail  = 0;

   rr_dff_arbiter #(.N(N), .W(W), .HOLD(2)) dut0 (
      .i_ck(clk), .i_rst(rst), .i_req(req0), .i_d(d0),
      .o_gnt(gnt0), .o_ack(ack0), .o_q(q0), .o_owner(own0), .o_busy(busy0));

   rr_dff_arbiter #(.N(N), .W(W), .HOLD(0)) dut1 (
      .i_ck(clk), .i_rst(rst), .i_req(req1), .i_d(d1),
      .o_gnt(gnt1), .o_ack(ack1), .o_q(q1), .o_owner(own1), .o_busy(busy1));

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each instance remembers the edge number g of its latest grant.
   // The write happens at edge g+1, BUSY covers edges g .. g+HOLD,
   // and a new request can win from edge g+2+HOLD onward.
   int e = 0;
   int g[2];
   int win[2];
   int ptr[2];
   int mq[2];
   int hold_of[2] = '{2, 0};

   initial begin
      int rq, dd, idx;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            for (int k = 0; k < 2; k++) begin
               g[k] = -1000; win[k] = 0; ptr[k] = 0; mq[k] = 0;
            end
         end else begin
            e = e + 1;
            for (int k = 0; k < 2; k++) begin
               rq = (k == 0) ? int'(req0) : int'(req1);
               dd = (k == 0) ? int'(d0) : int'(d1);
               if (e == g[k] + 1) begin
                  mq[k]  = (dd >> (win[k] * W)) & 8'hFF;
                  ptr[k] = (win[k] + 1) % N;
               end else if (e >= g[k] + 2 + hold_of[k] && rq != 0) begin
                  for (int j = N - 1; j >= 0; j--) begin
                     idx = (ptr[k] + j) % N;
                     if (((rq >> idx) & 1) == 1) win[k] = idx;
                  end
                  g[k] = e;
               end
            end
         end
      end
   end

   // Every cycle: compare both instances against the model on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            int eg, ea, eb;
            eg = (e == g[k]) ? (1 << win[k]) : 0;
            ea = (e == g[k] + 1) ? 1 : 0;
            eb = (e >= g[k] && e < g[k] + 1 + hold_of[k]) ? 1 : 0;
            if (k == 0) begin
               check("m_gnt0", int'(gnt0), eg);
               check("m_ack0", int'(ack0), ea);
               check("m_q0", int'(q0), mq[0]);
               check("m_own0", int'(own0), win[0]);
               check("m_busy0", int'(busy0), eb);
            end else begin
               check("m_gnt1", int'(gnt1), eg);
               check("m_ack1", int'(ack1), ea);
               check("m_q1", int'(q1), mq[1]);
               check("m_own1", int'(own1), win[1]);
               check("m_busy1", int'(busy1), eb);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a tick: pulses reset well clear of both clock edges.
   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   int exp3[5] = '{0, 1, 2, 3, 0};

   initial begin
      tick(); tick();
      #2 rst = 1'b0;
      tick();
      check("rst_gnt", int'(gnt0), 0);
      check("rst_q", int'(q0), 0);
      check("rst_own", int'(own0), 0);
      check("rst_busy", int'(busy0), 0);

      // Single request from reset: latency, ACK and BUSY timing.
      req0 = 4'b0001; d0[7:0] = 8'hA5;
      tick();
      check("t2_gnt_c1", int'(gnt0), 1);
      check("t2_busy_c1", int'(busy0), 1);
      tick();
      check("t2_q_c2", int'(q0), 8'hA5);
      check("t2_ack_c2", int'(ack0), 1);
      req0 = 4'b0000;
      tick();
      check("t2_ack_c3", int'(ack0), 0);
      check("t2_busy_c3", int'(busy0), 1);
      tick();
      check("t2_busy_c4", int'(busy0), 0);

      // Asynchronous reset in the first HOLD cycle.
      req0 = 4'b0001; d0[7:0] = 8'h77;
      tick(); tick();
      req0 = 4'b0000;
      check("t1_q_pre", int'(q0), 8'h77);
      #2 rst = 1'b1;
      #1;
      check("t1_gnt", int'(gnt0), 0);
      check("t1_ack", int'(ack0), 0);
      check("t1_q", int'(q0), 0);
      check("t1_busy", int'(busy0), 0);
      rst = 1'b0;

      // All requesting: rotation 0,1,2,3,0 with a 4-cycle grant period.
      tick();
      req0 = 4'b1111; d0 = 32'h13121110;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_owner", int'(own0), exp3[i]);
         check("t3_gnt", int'(gnt0), 1 << exp3[i]);
         tick();
         check("t3_q", int'(q0), 8'h10 + exp3[i]);
         tick(); tick();
      end
      req0 = 4'b0000;
      tick(); tick(); tick(); tick();

      // Pointer wrap: after owner 2, requests 3 and 0 are served 3 first.
      pulse_reset();
      req0 = 4'b0100;
      tick();
      check("t4_own2", int'(own0), 2);
      req0 = 4'b1001;
      tick(); tick(); tick(); tick();
      check("t4_own3", int'(own0), 3);
      check("t4_gnt3", int'(gnt0), 8);
      tick(); tick(); tick(); tick();
      check("t4_own0", int'(own0), 0);
      check("t4_gnt0", int'(gnt0), 1);
      req0 = 4'b0000;
      tick(); tick(); tick(); tick();

      // Request dropped during GRANT: the write still completes, with no regrant.
      pulse_reset();
      req0 = 4'b0100; d0[23:16] = 8'h3C;
      tick();
      check("t5_gnt", int'(gnt0), 4);
      req0 = 4'b0000;
      tick();
      check("t5_q", int'(q0), 8'h3C);
      check("t5_ack", int'(ack0), 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t5_nogrant", int'(gnt0), 0);
      end

      // HOLD=0 instance: grants alternate on every other cycle.
      pulse_reset();
      req1 = 4'b0011; d1[7:0] = 8'h55; d1[15:8] = 8'h66;
      tick();
      check("t6_gnt_a", int'(gnt1), 1);
      tick();
      check("t6_ack_a", int'(ack1), 1);
      check("t6_q_a", int'(q1), 8'h55);
      check("t6_busy_a", int'(busy1), 0);
      tick();
      check("t6_gnt_b", int'(gnt1), 2);
      tick();
      check("t6_ack_b", int'(ack1), 1);
      check("t6_q_b", int'(q1), 8'h66);
      tick();
      check("t6_gnt_c", int'(gnt1), 1);
      req1 = 4'b0000;
      tick(); tick();

      // Random traffic on both instances, with occasional asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 1) == 0) req0 = N'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) req1 = N'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) d0 = $urandom;
         if ($urandom_range(0, 3) == 0) d1 = $urandom;
         tick();
         if ($urandom_range(0, 299) == 0) pulse_reset();
      end
      req0 = '0; req1 = '0;
      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
